// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch, data and host: grants are combinational (0 cycles), read data returns 1 cycle later.
// Backpressure: a requester holds its request until gnt; fixed priority with starvation escalation and host burst locking.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAXWAIT = 4,
    parameter int MAXLOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    input  logic          ho_req,
    input  logic          ho_we,
    input  logic          ho_lock,
    input  logic [AW-1:0] ho_addr,
    input  logic [DW-1:0] ho_wdata,
    output logic          ho_gnt,
    output logic          ho_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
);

    typedef enum logic {FREE, LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_HO} owner_t;

    state_t     state;
    owner_t     tag;
    logic [3:0] ho_wait;
    logic [3:0] if_wait;
    logic [7:0] lock_cnt;
    logic       relock_block;

    logic ho_esc;
    logic if_esc;
    logic others_pending;
    logic relock_ok;

    assign ho_esc         = ho_wait >= 4'(MAXWAIT);
    assign if_esc         = if_wait >= 4'(MAXWAIT);
    assign others_pending = dm_req | if_req;
    // After a forced release the host may only re-lock once someone else had a turn.
    assign relock_ok      = !relock_block || !others_pending;

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        ho_gnt = 1'b0;
        if (!reset) begin
            if (state == LOCKED)        ho_gnt = ho_req;
            else if (ho_req && ho_esc)  ho_gnt = 1'b1;
            else if (if_req && if_esc)  if_gnt = 1'b1;
            else if (dm_req)            dm_gnt = 1'b1;
            else if (ho_req)            ho_gnt = 1'b1;
            else if (if_req)            if_gnt = 1'b1;
        end
    end

    always_comb begin
        mem_addr  = if_addr;
        mem_wdata = dm_wdata;
        mem_we    = 1'b0;
        if (dm_gnt) begin
            mem_addr = dm_addr;
            mem_we   = dm_we;
        end else if (ho_gnt) begin
            mem_addr  = ho_addr;
            mem_wdata = ho_wdata;
            mem_we    = ho_we;
        end
    end

    assign rdata     = mem_rdata;
    assign locked    = (state == LOCKED);
    assign if_rvalid = (tag == OWN_IF);
    assign dm_rvalid = (tag == OWN_DM);
    assign ho_rvalid = (tag == OWN_HO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FREE;
            tag          <= OWN_NONE;
            ho_wait      <= 4'd0;
            if_wait      <= 4'd0;
            lock_cnt     <= 8'd0;
            relock_block <= 1'b0;
        end else begin
            if (ho_req && !ho_gnt) ho_wait <= (ho_wait == 4'hF) ? ho_wait : ho_wait + 4'd1;
            else                   ho_wait <= 4'd0;
            if (if_req && !if_gnt) if_wait <= (if_wait == 4'hF) ? if_wait : if_wait + 4'd1;
            else                   if_wait <= 4'd0;

            if (if_gnt)                 tag <= OWN_IF;
            else if (dm_gnt && !dm_we)  tag <= OWN_DM;
            else if (ho_gnt && !ho_we)  tag <= OWN_HO;
            else                        tag <= OWN_NONE;

            case (state)
                FREE: begin
                    if (ho_gnt && ho_lock && relock_ok) begin
                        lock_cnt <= 8'd1;
                        if (MAXLOCK <= 1) begin
                            relock_block <= 1'b1;
                        end else begin
                            state        <= LOCKED;
                            relock_block <= 1'b0;
                        end
                    end else if (if_gnt || dm_gnt || !others_pending) begin
                        relock_block <= 1'b0;
                    end
                end
                LOCKED: begin
                    // ho_gnt == ho_req here, so a dropped request or lock ends the burst.
                    if (!ho_req || !ho_lock) begin
                        state <= FREE;
                    end else if (lock_cnt >= 8'(MAXLOCK - 1)) begin
                        state        <= FREE;
                        relock_block <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a rule-level model and a memory shadow.
module tb_mem_port_arbiter;
    localparam int AW = 16, DW = 16, MAXWAIT = 4, MAXLOCK = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic          ho_req = 1'b0, ho_we = 1'b0, ho_lock = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0, ho_addr = '0;
    logic [DW-1:0] dm_wdata = '0, ho_wdata = '0;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, ho_gnt, ho_rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we, locked;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT), .MAXLOCK(MAXLOCK)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .ho_req(ho_req), .ho_we(ho_we), .ho_lock(ho_lock), .ho_addr(ho_addr),
        .ho_wdata(ho_wdata), .ho_gnt(ho_gnt), .ho_rvalid(ho_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    // Memory macro: synchronous read, write on mem_we.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] shadow [256];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: requester ids 0 none, 1 IF, 2 DM, 3 HO.
    int            m_how = 0, m_ifw = 0, m_lcnt = 0, m_pend = 0;
    bit            m_lock = 0, m_block = 0;
    logic [DW-1:0] m_pdata = '0;

    always @(negedge clk) begin : compare
        int            g;
        bit            gwe, others;
        logic [AW-1:0] gaddr;
        logic [DW-1:0] gwdata;
        g = 0;
        if (!reset) begin
            if (m_lock)                         g = ho_req ? 3 : 0;
            else if (ho_req && m_how >= MAXWAIT) g = 3;
            else if (if_req && m_ifw >= MAXWAIT) g = 1;
            else if (dm_req)                    g = 2;
            else if (ho_req)                    g = 3;
            else if (if_req)                    g = 1;
        end
        gwe    = (g == 2) ? dm_we : (g == 3) ? ho_we : 1'b0;
        gaddr  = (g == 2) ? dm_addr : (g == 3) ? ho_addr : if_addr;
        gwdata = (g == 2) ? dm_wdata : ho_wdata;

        check("grant", 32'({if_gnt, dm_gnt, ho_gnt}), 32'({g == 1, g == 2, g == 3}));
        check("rvalid", 32'({if_rvalid, dm_rvalid, ho_rvalid}),
              reset ? 32'd0 : 32'({m_pend == 1, m_pend == 2, m_pend == 3}));
        check("locked", 32'(locked), 32'(m_lock && !reset));
        check("mem_cmd", 32'({mem_we, mem_addr}), 32'({gwe, gaddr}));
        if (gwe) check("mem_wdata", 32'(mem_wdata), 32'(gwdata));
        if (!reset && m_pend != 0) check("rdata", 32'(rdata), 32'(m_pdata));

        if (reset) begin
            m_how = 0; m_ifw = 0; m_lcnt = 0; m_pend = 0; m_lock = 0; m_block = 0;
        end else begin
            others = dm_req || if_req;
            m_how  = (ho_req && g != 3) ? ((m_how < 15) ? m_how + 1 : 15) : 0;
            m_ifw  = (if_req && g != 1) ? ((m_ifw < 15) ? m_ifw + 1 : 15) : 0;
            if (m_lock) begin
                if (g == 3) begin
                    m_lcnt++;
                    if (!ho_lock) m_lock = 0;
                    else if (m_lcnt >= MAXLOCK) begin m_lock = 0; m_block = 1; end
                end else begin
                    m_lock = 0;
                end
            end else if (g == 3 && ho_lock && (!m_block || !others)) begin
                m_lcnt = 1;
                if (MAXLOCK <= 1) m_block = 1;
                else begin m_lock = 1; m_block = 0; end
            end else if (g == 1 || g == 2 || !others) begin
                m_block = 0;
            end
            if (g != 0 && !gwe) begin
                m_pend  = g;
                m_pdata = shadow[gaddr[7:0]];
            end else begin
                m_pend = 0;
            end
            if (gwe) shadow[gaddr[7:0]] = gwdata;
        end
    end

    task automatic drive();
        @(posedge clk); #1;
    endtask
    task automatic sample();
        @(negedge clk); #1;
    endtask
    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 63));
    endfunction

    task automatic single_fetch();
        drive(); if_req = 1'b1; if_addr = 16'h0010;
        sample(); check("s1_if_gnt", 32'({if_gnt, dm_gnt, ho_gnt}), 32'b100);
        drive(); if_req = 1'b0;
        sample(); check("s1_if_rvalid", 32'({if_rvalid, dm_rvalid, ho_rvalid}), 32'b100);
        check("s1_rdata", 32'(rdata), 32'h0000BEEF);
    endtask

    initial begin
        int if_first, ho_first, ho_cnt, dm_cnt;
        bit gi, gd, gh;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = DW'(i * 16'h0101) ^ 16'h5A5A;
            shadow[i] = DW'(i * 16'h0101) ^ 16'h5A5A;
        end
        mem[16] = 16'hBEEF; shadow[16] = 16'hBEEF;

        repeat (3) sample();
        check("reset_state", 32'({if_gnt, dm_gnt, ho_gnt, if_rvalid, dm_rvalid, ho_rvalid, locked}), 32'd0);
        drive(); reset = 1'b0;

        single_fetch();

        // Priority and escalation: DM writes every cycle against waiting HO and IF.
        drive();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h1111;
        ho_req = 1'b1; ho_we = 1'b0; ho_addr = 16'h0040;
        if_req = 1'b1; if_addr = 16'h0011;
        if_first = -1; ho_first = -1; dm_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            gi = if_gnt; gh = ho_gnt;
            if (c < 4 && dm_gnt) dm_cnt++;
            if (gh && ho_first < 0) ho_first = c;
            if (gi && if_first < 0) if_first = c;
            drive();
            dm_wdata = dm_wdata + 16'd1;
            if (gh) ho_req = 1'b0;
            if (gi) if_req = 1'b0;
        end
        dm_req = 1'b0;
        check("prio_dm_first4", 32'(dm_cnt), 32'd4);
        check("prio_ho_cycle", 32'(ho_first), 32'd4);
        check("prio_if_cycle", 32'(if_first), 32'd5);

        // Write then read back.
        drive(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
        sample(); check("wr_mem_we", 32'({dm_gnt, mem_we}), 32'b11);
        drive(); dm_we = 1'b0;
        sample(); check("wr_no_rvalid", 32'({if_rvalid, dm_rvalid, ho_rvalid}), 32'd0);
        drive(); dm_req = 1'b0;
        sample(); check("rd_rvalid", 32'(dm_rvalid), 32'd1);
        check("rd_rdata", 32'(rdata), 32'h00001234);

        // Host lock burst of three writes with DM waiting.
        drive(); ho_req = 1'b1; ho_lock = 1'b1; ho_we = 1'b1; ho_addr = 16'h0050; ho_wdata = 16'hA000;
        sample(); check("lk_first_gnt", 32'(ho_gnt), 32'd1);
        drive(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0021; ho_addr = 16'h0051;
        sample(); check("lk_2nd", 32'({locked, dm_gnt, ho_gnt}), 32'b101);
        drive(); ho_addr = 16'h0052; ho_lock = 1'b0;
        sample(); check("lk_3rd", 32'({locked, dm_gnt, ho_gnt}), 32'b101);
        drive(); ho_req = 1'b0;
        sample(); check("lk_release", 32'({locked, dm_gnt}), 32'b01);
        drive(); dm_req = 1'b0;

        // Lock timeout with a pending fetch.
        drive(); ho_req = 1'b1; ho_lock = 1'b1; ho_we = 1'b1; ho_addr = 16'h0060;
        if_req = 1'b1; if_addr = 16'h0012;
        ho_cnt = 0; if_first = -1;
        for (int c = 0; c < 20; c++) begin
            sample();
            gi = if_gnt;
            if (if_first < 0 && ho_gnt) ho_cnt++;
            if (gi && if_first < 0) begin
                if_first = c;
                check("to_unlocked_at_if", 32'(locked), 32'd0);
            end
            drive();
            ho_wdata = ho_wdata + 16'd1;
            if (gi) if_req = 1'b0;
        end
        check("to_ho_grants", 32'(ho_cnt), 32'(MAXLOCK));
        check("to_if_cycle", 32'(if_first), 32'(MAXLOCK));
        ho_req = 1'b0; ho_lock = 1'b0;
        repeat (2) drive();

        // Reset the cycle after a DM read grant.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010;
        sample(); check("rst_rd_gnt", 32'(dm_gnt), 32'd1);
        drive(); dm_req = 1'b0; reset = 1'b1;
        sample(); check("rst_mid_read", 32'({if_gnt, dm_gnt, ho_gnt, if_rvalid, dm_rvalid, ho_rvalid, locked}), 32'd0);
        drive(); reset = 1'b0;
        sample(); check("rst_no_stale", 32'({if_rvalid, dm_rvalid, ho_rvalid}), 32'd0);
        single_fetch();

        // Random traffic obeying the hold-until-grant handshake.
        for (int c = 0; c < 3000; c++) begin
            sample();
            gi = if_gnt; gd = dm_gnt; gh = ho_gnt;
            drive();
            reset = ($urandom_range(0, 299) == 0);
            if (!if_req || gi) begin
                if_req  = ($urandom_range(0, 99) < 50);
                if_addr = rand_addr();
            end
            if (!dm_req || gd) begin
                dm_req   = ($urandom_range(0, 99) < 40);
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = rand_addr();
                dm_wdata = DW'($urandom);
            end
            if (!ho_req || gh) begin
                ho_req   = ($urandom_range(0, 99) < (gh ? 85 : 30));
                ho_we    = 1'($urandom_range(0, 1));
                ho_lock  = ($urandom_range(0, 3) != 0);
                ho_addr  = rand_addr();
                ho_wdata = DW'($urandom);
            end
        end
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; ho_req = 1'b0;
        repeat (3) sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
